// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================
// fib_pkg : shared FSM state encoding and mode constants
// Rev 1.0
// ============================================================
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fib_step.sv
`default_nettype none
// ============================================================
// fib_step : one Fibonacci step (A,B) -> (B, A+B) with sticky overflow
// Rev 1.0
// ============================================================
module fib_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ovf,
  input  logic             b_ovf,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             a_ovf_nxt,
  output logic             b_ovf_nxt
);

  logic carry;

  // Carry out of the sum marks the first term that no longer fits
  always_comb begin
    {carry, b_nxt} = {1'b0, a} + {1'b0, b};
  end

  assign a_nxt     = b;
  assign a_ovf_nxt = b_ovf;
  assign b_ovf_nxt = a_ovf | b_ovf | carry;

endmodule
`default_nettype wire

// File: rtl/fib_seq_gen.sv
`default_nettype none
// ============================================================
// fib_seq_gen : Fibonacci F(0..n) generator, single or stream mode
// Rev 1.0
// ============================================================
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] n,
  input  logic             mode,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             overflow,
  output logic             done
);
  import fib_pkg::*;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, a_nxt, b_nxt;
  logic [IDX_W-1:0] k, n_q;
  logic             a_ovf, b_ovf, a_ovf_nxt, b_ovf_nxt;
  logic             mode_q;
  logic             load, step, done_nxt;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a         (a),
    .b         (b),
    .a_ovf     (a_ovf),
    .b_ovf     (b_ovf),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .a_ovf_nxt (a_ovf_nxt),
    .b_ovf_nxt (b_ovf_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (mode == MODE_STREAM) ? OUT : CALC;
        end
      end
      CALC: begin
        if (k == n_q || mode_q == MODE_STREAM) state_nxt = OUT;
        else                                   step      = 1'b1;
      end
      OUT: begin
        if (out_ready) begin
          if (k == n_q) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= WIDTH'(1);
      k      <= '0;
      a_ovf  <= 1'b0;
      b_ovf  <= 1'b0;
      n_q    <= '0;
      mode_q <= MODE_SINGLE;
      done   <= 1'b0;
    end else begin
      done <= done_nxt;
      if (load) begin
        n_q    <= n;
        mode_q <= mode;
        a      <= '0;
        b      <= WIDTH'(1);
        k      <= '0;
        a_ovf  <= 1'b0;
        b_ovf  <= 1'b0;
      end else if (step) begin
        a     <= a_nxt;
        b     <= b_nxt;
        k     <= k + IDX_W'(1);
        a_ovf <= a_ovf_nxt;
        b_ovf <= b_ovf_nxt;
      end
    end
  end

  // Outputs are forced to zero outside OUT so idle/reset presents a clean bus
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = !out_valid ? '0 : ((SAT && a_ovf) ? {WIDTH{1'b1}} : a);
  assign out_idx   = out_valid ? k : '0;
  assign overflow  = out_valid & a_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
`default_nettype none
// ============================================================
// tb_fib_seq_gen : directed self-checking bench for fib_seq_gen
// Rev 1.0
// ============================================================
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, mode, out_ready;
  logic [7:0]  n;

  logic        busy, out_valid, overflow, done;
  logic [31:0] out_data;
  logic [7:0]  out_idx;

  logic        d8_busy, d8_valid, d8_ovf, d8_done;
  logic [7:0]  d8_data, d8_idx;
  logic        s8_busy, s8_valid, s8_ovf, s8_done;
  logic [7:0]  s8_data, s8_idx;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] fib_tab [0:14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377};

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(32), .IDX_W(8), .SAT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .overflow(overflow), .done(done)
  );

  fib_seq_gen #(.WIDTH(8), .IDX_W(8), .SAT(1'b0)) u_dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode), .out_ready(out_ready),
    .busy(d8_busy), .out_valid(d8_valid), .out_data(d8_data), .out_idx(d8_idx),
    .overflow(d8_ovf), .done(d8_done)
  );

  fib_seq_gen #(.WIDTH(8), .IDX_W(8), .SAT(1'b1)) u_dut_sat8 (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode), .out_ready(out_ready),
    .busy(s8_busy), .out_valid(s8_valid), .out_data(s8_data), .out_idx(s8_idx),
    .overflow(s8_ovf), .done(s8_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-mode request; poke pulses a conflicting start while busy
  task automatic run_single(input int nn, input logic [7:0] e8, input logic o8, input bit poke);
    int cnt;
    out_ready = 1'b1;
    start = 1'b1; n = nn[7:0]; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      if (poke && cnt == 2) begin
        start = 1'b1; n = 8'd3; mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cnt++;
    end
    start = 1'b0;
    chk("latency", cnt, nn + 1);
    chk("data", out_data, fib_tab[nn]);
    chk("idx", out_idx, nn);
    chk("ovf", overflow, 0);
    chk("w8_data", d8_data, e8);
    chk("w8_ovf", d8_ovf, o8);
    chk("sat8_data", s8_data, o8 ? 8'hFF : e8);
    chk("sat8_ovf", s8_ovf, o8);
    tick();
    chk("done_pulse", done, 1);
    chk("valid_low_at_done", out_valid, 0);
    chk("busy_low", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  // Stream-mode request; pat supplies out_ready per cycle (bit c mod 16)
  task automatic run_stream(input int nn, input logic [15:0] pat);
    int e;
    int c;
    start = 1'b1; n = nn[7:0]; mode = 1'b1; out_ready = pat[0];
    tick();
    start = 1'b0;
    e = 0;
    c = 0;
    while (e <= nn && c < 60) begin
      out_ready = pat[c % 16];
      chk("s_valid", out_valid, 1);
      chk("s_data", out_data, fib_tab[e]);
      chk("s_idx", out_idx, e);
      chk("s_done_low", done, 0);
      tick();
      if (out_ready) e++;
      c++;
    end
    chk("s_terms", e, nn + 1);
    chk("s_done", done, 1);
    chk("s_valid_end", out_valid, 0);
    tick();
    chk("s_done_clear", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n = '0; mode = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_single(10, 8'd55, 1'b0, 1'b0);
    run_single(13, 8'd233, 1'b0, 1'b0);
    run_single(14, 8'd121, 1'b1, 1'b0);
    run_single(0, 8'd0, 1'b0, 1'b0);
    run_single(1, 8'd1, 1'b0, 1'b0);
    run_single(10, 8'd55, 1'b0, 1'b1);

    run_stream(5, 16'hFFFF);
    run_stream(5, 16'b0101_1001_0110_1001);
    run_stream(0, 16'hFFFF);

    // Asynchronous reset while idx 4 is being presented
    start = 1'b1; n = 8'd5; mode = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_idx", out_idx, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    run_stream(2, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Parametrised Fibonacci engine; successor to the free-running 32-bit generator.
- Computes F(0..n) on request. F(0)=0, F(1)=1.
- Two modes: single result (F(n) only) or stream (every term F(0)..F(n)).
- Output uses a valid/ready handshake, with overflow detection and optional saturation. Used as a test-pattern and sequence source feeding downstream datapath blocks.

Parameters:
- WIDTH, 32, bit width of term registers and out_data.
- IDX_W, 8, width of requested index n and out_idx.
- SAT, 0, 1 = overflowed terms are presented as all-ones; 0 = terms wrap mod 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- n  in  IDX_W  requested final index; latched on accepted start.
- mode  in  1  0 = single, 1 = stream; latched on accepted start.
- out_ready  in  1  downstream ready.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  out_data/out_idx/overflow valid.
- out_data  out  WIDTH  term value.
- out_idx  out  IDX_W  index i of the presented term F(i).
- overflow  out  1  presented term exceeded 2^WIDTH-1 (sticky along the sequence).
- done  out  1  one-cycle pulse after the final term handshake.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; internal A=0, B=1, k=0.
  - Ovf flags cleared; latched n/mode cleared.
  - Reset mid-operation drops any pending term; no done is issued.
- State machine, IDLE / CALC / OUT:
  - IDLE: start=1 latches n and mode, loads A=0, B=1, k=0, a_ovf=0, b_ovf=0, then goes to CALC (mode=0) or OUT (mode=1).
  - CALC (single mode only): if k==n, go to OUT without stepping; else step. F(n) therefore becomes valid exactly n+1 edges after the start edge (n=0 gives 1 cycle).
  - OUT: out_valid=1, out_data=A, out_idx=k, overflow=a_ovf.
    - Handshake (out_valid && out_ready) with k==n: go to IDLE and pulse done on the same edge.
    - Handshake with k<n (stream): step and stay in OUT, giving back-to-back throughput of 1 term/cycle.
    - No handshake: hold all outputs stable.
- Step: A<=B; B<=A+B (WIDTH-bit, carry discarded); k<=k+1; a_ovf<=b_ovf; b_ovf<=a_ovf | b_ovf | carry(A+B).
- Saturation: with SAT=1 and a_ovf=1, out_data=all-ones. Internal registers still wrap.
- start while busy is ignored, with no queueing. Changes to n/mode while busy have no effect.
- n=0 in stream mode: a single term 0 with idx 0, then done.
- done and out_valid are never high in the same cycle.

Decomposition:
- Shared package fib_pkg: state enum (IDLE, CALC, OUT) and mode constants MODE_SINGLE=0, MODE_STREAM=1.
- One sub-module, fib_step: combinational WIDTH-parametrised adder producing next A/B, carry and next ovf flags. It is instantiated once in fib_seq_gen.

Test Plan:
- WIDTH=32, mode=0, n=10, out_ready=1 → out_valid rises 11 edges after start; out_data=55, out_idx=10, overflow=0; done next cycle; busy low after.
- mode=1, n=5, out_ready=1 → out_data 0,1,1,2,3,5 on consecutive cycles with idx 0..5, then done.
- mode=1, n=5, out_ready toggled 1,0,0,1,... → terms hold stable while ready=0, no term skipped or duplicated.
- Overflow:
  - WIDTH=8, SAT=0, mode=0, n=13 → 233, overflow=0.
  - WIDTH=8, SAT=0, mode=0, n=14 → 121 (377 mod 256), overflow=1.
  - Same n=14 with SAT=1 → 255, overflow=1.
- Edge indices: n=0 single → 0 after 1 cycle; n=1 → 1 after 2 cycles. start pulsed while busy → ignored, result unchanged.
- Reset mid-stream (rst_n low after idx 3 handshake) → outputs 0 immediately (async), state IDLE, no done. A new start with n=2 then yields a correct 0,1,1 stream.
